// File: rtl/urisc_mem_arbiter.sv
// Two-requester arbiter for the URISC data memory port (core vs host loader).
// Each access goes IDLE -> ISSUE -> [WAIT x RD_LAT] -> RESP; every output is registered.
module urisc_mem_arbiter #(
    parameter int AW        = 9,
    parameter int DW        = 16,
    parameter int RD_LAT    = 1,
    parameter int HOST_PRIO = 0
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_core_req,
    input  logic          i_core_we,
    input  logic [AW-1:0] i_core_addr,
    input  logic [DW-1:0] i_core_wdata,
    output logic          o_core_ack,
    output logic [DW-1:0] o_core_rdata,
    input  logic          i_host_req,
    input  logic          i_host_we,
    input  logic [AW-1:0] i_host_addr,
    input  logic [DW-1:0] i_host_wdata,
    output logic          o_host_ack,
    output logic [DW-1:0] o_host_rdata,
    output logic          o_mem_cs,
    output logic          o_mem_read,
    output logic          o_mem_write,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata,
    output logic          o_busy,
    output logic          o_owner
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Wait counter runs down from RD_LAT-1; the cycle it reads 0 is the capture cycle.
    localparam logic [2:0] LAT_TC = 3'(RD_LAT - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic          r_we;
    logic          r_owner;
    logic          r_rr_host;
    logic [2:0]    r_wait_cnt;
    logic          r_busy;
    logic          r_core_ack;
    logic          r_host_ack;
    logic [DW-1:0] r_core_rdata;
    logic [DW-1:0] r_host_rdata;
    logic          r_mem_cs;
    logic          r_mem_read;
    logic          r_mem_write;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;

    logic          w_grant_host;
    logic          w_issue;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    always_comb begin
        w_next_state = r_state;
        w_grant_host = 1'b0;
        if (HOST_PRIO != 0) begin
            w_grant_host = i_host_req;
        end else begin
            w_grant_host = i_host_req & (~i_core_req | r_rr_host);
        end
        w_issue     = (r_state == S_IDLE) && (i_core_req || i_host_req);
        w_sel_we    = w_grant_host ? i_host_we    : i_core_we;
        w_sel_addr  = w_grant_host ? i_host_addr  : i_core_addr;
        w_sel_wdata = w_grant_host ? i_host_wdata : i_core_wdata;
        case (r_state)
            S_IDLE:  if (w_issue) w_next_state = S_ISSUE;
            S_ISSUE: w_next_state = r_we ? S_RESP : S_WAIT;
            S_WAIT:  if (r_wait_cnt == 3'd0) w_next_state = S_RESP;
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_owner      <= 1'b0;
            r_rr_host    <= 1'b0;
            r_wait_cnt   <= 3'd0;
            r_busy       <= 1'b0;
            r_core_ack   <= 1'b0;
            r_host_ack   <= 1'b0;
            r_core_rdata <= '0;
            r_host_rdata <= '0;
            r_mem_cs     <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_state     <= w_next_state;
            r_busy      <= (w_next_state != S_IDLE);
            r_mem_cs    <= w_issue;
            r_mem_read  <= w_issue & ~w_sel_we;
            r_mem_write <= w_issue & w_sel_we;
            r_mem_addr  <= w_issue ? w_sel_addr : '0;
            r_mem_wdata <= (w_issue && w_sel_we) ? w_sel_wdata : '0;
            r_core_ack  <= (w_next_state == S_RESP) && !r_owner;
            r_host_ack  <= (w_next_state == S_RESP) && r_owner;
            if (w_issue) begin
                r_we    <= w_sel_we;
                r_owner <= w_grant_host;
            end
            if (r_state == S_ISSUE) begin
                r_wait_cnt <= LAT_TC;
            end else if (r_state == S_WAIT && r_wait_cnt != 3'd0) begin
                r_wait_cnt <= r_wait_cnt - 3'd1;
            end
            if (r_state == S_WAIT && r_wait_cnt == 3'd0) begin
                if (r_owner) r_host_rdata <= i_mem_rdata;
                else         r_core_rdata <= i_mem_rdata;
            end
            if (r_state == S_RESP) begin
                r_rr_host <= ~r_owner;
            end
        end
    end

    assign o_core_ack   = r_core_ack;
    assign o_core_rdata = r_core_rdata;
    assign o_host_ack   = r_host_ack;
    assign o_host_rdata = r_host_rdata;
    assign o_mem_cs     = r_mem_cs;
    assign o_mem_read   = r_mem_read;
    assign o_mem_write  = r_mem_write;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_busy       = r_busy;
    assign o_owner      = r_owner;

endmodule

// File: tb/tb_urisc_mem_arbiter.sv
// Directed bench for urisc_mem_arbiter: three instances (round-robin/RD_LAT=1,
// host-priority/RD_LAT=1, round-robin/RD_LAT=3), each with a synchronous memory model.
module tb_urisc_mem_arbiter;

    logic clk;
    logic tb_init;
    int   n_total;
    int   n_bad;

    logic        rst        [3];
    logic        core_req   [3];
    logic        core_we    [3];
    logic [8:0]  core_addr  [3];
    logic [15:0] core_wdata [3];
    logic        host_req   [3];
    logic        host_we    [3];
    logic [8:0]  host_addr  [3];
    logic [15:0] host_wdata [3];

    logic        core_ack   [3];
    logic [15:0] core_rdata [3];
    logic        host_ack   [3];
    logic [15:0] host_rdata [3];
    logic        mem_cs     [3];
    logic        mem_read   [3];
    logic        mem_write  [3];
    logic [8:0]  mem_addr   [3];
    logic [15:0] mem_wdata  [3];
    logic        busy       [3];
    logic        owner      [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 2) ? 3 : 1;
        localparam int HP  = (g == 1) ? 1 : 0;

        logic        w_core_ack;
        logic [15:0] w_core_rdata;
        logic        w_host_ack;
        logic [15:0] w_host_rdata;
        logic        w_mem_cs;
        logic        w_mem_read;
        logic        w_mem_write;
        logic [8:0]  w_mem_addr;
        logic [15:0] w_mem_wdata;
        logic [15:0] w_mem_rdata;
        logic        w_busy;
        logic        w_owner;
        logic [15:0] mem  [512];
        logic [15:0] pipe [3];

        urisc_mem_arbiter #(.AW(9), .DW(16), .RD_LAT(LAT), .HOST_PRIO(HP)) u_dut (
            .i_clk        (clk),
            .i_reset      (rst[g]),
            .i_core_req   (core_req[g]),
            .i_core_we    (core_we[g]),
            .i_core_addr  (core_addr[g]),
            .i_core_wdata (core_wdata[g]),
            .o_core_ack   (w_core_ack),
            .o_core_rdata (w_core_rdata),
            .i_host_req   (host_req[g]),
            .i_host_we    (host_we[g]),
            .i_host_addr  (host_addr[g]),
            .i_host_wdata (host_wdata[g]),
            .o_host_ack   (w_host_ack),
            .o_host_rdata (w_host_rdata),
            .o_mem_cs     (w_mem_cs),
            .o_mem_read   (w_mem_read),
            .o_mem_write  (w_mem_write),
            .o_mem_addr   (w_mem_addr),
            .o_mem_wdata  (w_mem_wdata),
            .i_mem_rdata  (w_mem_rdata),
            .o_busy       (w_busy),
            .o_owner      (w_owner)
        );

        // Memory preloads to 0xA000|addr; read data emerges LAT cycles after CS&Read.
        always @(posedge clk) begin
            if (tb_init) begin
                for (int i = 0; i < 512; i++) mem[i] <= 16'hA000 | 16'(i);
            end else if (w_mem_cs && w_mem_write) begin
                mem[w_mem_addr] <= w_mem_wdata;
            end
            pipe[0] <= (w_mem_cs && w_mem_read) ? mem[w_mem_addr] : 16'hDEAD;
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        assign w_mem_rdata = pipe[LAT-1];

        assign core_ack[g]   = w_core_ack;
        assign core_rdata[g] = w_core_rdata;
        assign host_ack[g]   = w_host_ack;
        assign host_rdata[g] = w_host_rdata;
        assign mem_cs[g]     = w_mem_cs;
        assign mem_read[g]   = w_mem_read;
        assign mem_write[g]  = w_mem_write;
        assign mem_addr[g]   = w_mem_addr;
        assign mem_wdata[g]  = w_mem_wdata;
        assign busy[g]       = w_busy;
        assign owner[g]      = w_owner;

        always @(negedge clk) begin
            if (!tb_init) begin
                chk("ack_excl", 32'(w_core_ack & w_host_ack), 32'd0);
                chk("strobe_excl", 32'(w_mem_read & w_mem_write), 32'd0);
                chk("cs_only_busy", 32'(w_mem_cs & ~w_busy), 32'd0);
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic req_core(input int d, input logic we, input logic [8:0] a, input logic [15:0] wd);
        core_req[d] = 1'b1; core_we[d] = we; core_addr[d] = a; core_wdata[d] = wd;
    endtask

    task automatic req_host(input int d, input logic we, input logic [8:0] a, input logic [15:0] wd);
        host_req[d] = 1'b1; host_we[d] = we; host_addr[d] = a; host_wdata[d] = wd;
    endtask

    function automatic logic [2:0] strobes(input int d);
        return {mem_cs[d], mem_read[d], mem_write[d]};
    endfunction

    function automatic logic [1:0] acks(input int d);
        return {core_ack[d], host_ack[d]};
    endfunction

    initial begin
        n_total = 0;
        n_bad   = 0;
        tb_init = 1'b1;
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1;
            core_req[d] = 1'b0; core_we[d] = 1'b0; core_addr[d] = '0; core_wdata[d] = '0;
            host_req[d] = 1'b0; host_we[d] = 1'b0; host_addr[d] = '0; host_wdata[d] = '0;
        end
        tick(2);
        tb_init = 1'b0;
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;

        // idle after reset: every output stays 0
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_outputs", {core_ack[0], host_ack[0], mem_cs[0], mem_read[0], mem_write[0],
                                 busy[0], owner[0], mem_addr[0], mem_wdata[0]}, 32'd0);
        end
        chk("idle_rdata", {core_rdata[0], host_rdata[0]}, 32'd0);

        // host write 0x005 = 0xBEEF
        req_host(0, 1'b1, 9'h005, 16'hBEEF);
        tick();
        chk("hw_strobes", 32'(strobes(0)), 32'b101);
        chk("hw_addr", 32'(mem_addr[0]), 32'h005);
        chk("hw_wdata", 32'(mem_wdata[0]), 32'hBEEF);
        chk("hw_owner", 32'(owner[0]), 32'd1);
        chk("hw_busy", 32'(busy[0]), 32'd1);
        host_req[0] = 1'b0;
        tick();
        chk("hw_ack", 32'(acks(0)), 32'b01);
        chk("hw_resp_strobes", 32'(strobes(0)), 32'd0);
        tick();
        chk("hw_done", {30'd0, acks(0)} | 32'(busy[0]), 32'd0);
        chk("hw_owner_hold", 32'(owner[0]), 32'd1);

        // core read 0x005; address change after grant must be ignored
        req_core(0, 1'b0, 9'h005, 16'h0);
        tick();
        chk("cr_strobes", 32'(strobes(0)), 32'b110);
        chk("cr_addr", 32'(mem_addr[0]), 32'h005);
        chk("cr_owner", 32'(owner[0]), 32'd0);
        core_req[0] = 1'b0;
        core_addr[0] = 9'h1FF;
        tick();
        chk("cr_wait", {29'd0, strobes(0)} | {31'd0, core_ack[0]}, 32'd0);
        chk("cr_wait_busy", 32'(busy[0]), 32'd1);
        tick();
        chk("cr_ack", 32'(acks(0)), 32'b10);
        chk("cr_rdata", 32'(core_rdata[0]), 32'hBEEF);
        chk("cr_host_rdata", 32'(host_rdata[0]), 32'h0);
        tick();
        chk("cr_ack_pulse", 32'(core_ack[0]), 32'd0);
        chk("cr_rdata_hold", 32'(core_rdata[0]), 32'hBEEF);

        // tie after reset: core first, then a fresh tie in IDLE goes to host
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        chk("rst_rdata", 32'(core_rdata[0]), 32'h0);
        req_core(0, 1'b0, 9'h005, 16'h0);
        req_host(0, 1'b0, 9'h007, 16'h0);
        tick();
        chk("tie1_owner", 32'(owner[0]), 32'd0);
        chk("tie1_addr", 32'(mem_addr[0]), 32'h005);
        core_req[0] = 1'b0;
        tick(2);
        chk("tie1_core_ack", 32'(acks(0)), 32'b10);
        chk("tie1_core_rdata", 32'(core_rdata[0]), 32'hBEEF);
        tick();
        req_core(0, 1'b0, 9'h00C, 16'h0);
        chk("tie_gap_idle", 32'(busy[0]), 32'd0);
        tick();
        chk("tie2_owner", 32'(owner[0]), 32'd1);
        chk("tie2_addr", 32'(mem_addr[0]), 32'h007);
        host_req[0] = 1'b0;
        tick(2);
        chk("tie2_host_ack", 32'(acks(0)), 32'b01);
        chk("tie2_host_rdata", 32'(host_rdata[0]), 32'hA007);
        chk("tie2_core_rdata", 32'(core_rdata[0]), 32'hBEEF);
        tick(2);
        chk("tie3_owner", 32'(owner[0]), 32'd0);
        chk("tie3_addr", 32'(mem_addr[0]), 32'h00C);
        core_req[0] = 1'b0;
        tick(2);
        chk("tie3_core_ack", 32'(acks(0)), 32'b10);
        chk("tie3_core_rdata", 32'(core_rdata[0]), 32'hA00C);
        tick();

        // host priority: host read beats simultaneous core write to same address
        req_core(1, 1'b1, 9'h010, 16'h1234);
        req_host(1, 1'b0, 9'h010, 16'h0);
        tick();
        chk("hp_owner", 32'(owner[1]), 32'd1);
        chk("hp_strobes", 32'(strobes(1)), 32'b110);
        host_req[1] = 1'b0;
        tick(2);
        chk("hp_host_ack", 32'(acks(1)), 32'b01);
        chk("hp_old_data", 32'(host_rdata[1]), 32'hA010);
        tick(2);
        chk("hp_core_owner", 32'(owner[1]), 32'd0);
        chk("hp_core_strobes", 32'(strobes(1)), 32'b101);
        chk("hp_core_wdata", 32'(mem_wdata[1]), 32'h1234);
        core_req[1] = 1'b0;
        tick();
        chk("hp_core_ack", 32'(acks(1)), 32'b10);
        chk("hp_wr_no_rdata", {core_rdata[1], host_rdata[1]}, 32'h0000A010);
        req_host(1, 1'b0, 9'h010, 16'h0);
        tick(2);
        chk("hp_reread_owner", 32'(owner[1]), 32'd1);
        host_req[1] = 1'b0;
        tick(2);
        chk("hp_reread_ack", 32'(acks(1)), 32'b01);
        chk("hp_new_data", 32'(host_rdata[1]), 32'h1234);

        // RD_LAT=3: full read, then a read aborted by reset in WAIT, then a clean read
        req_core(2, 1'b0, 9'h003, 16'h0);
        tick();
        chk("l3_strobes", 32'(strobes(2)), 32'b110);
        core_req[2] = 1'b0;
        tick(3);
        chk("l3_no_early_ack", 32'(core_ack[2]), 32'd0);
        chk("l3_busy", 32'(busy[2]), 32'd1);
        tick();
        chk("l3_ack", 32'(core_ack[2]), 32'd1);
        chk("l3_rdata", 32'(core_rdata[2]), 32'hA003);
        tick();
        req_core(2, 1'b0, 9'h004, 16'h0);
        tick();
        core_req[2] = 1'b0;
        tick(2);
        chk("abort_in_wait", 32'(busy[2]), 32'd1);
        rst[2] = 1'b1;
        tick();
        rst[2] = 1'b0;
        chk("abort_busy", 32'(busy[2]), 32'd0);
        chk("abort_rdata", 32'(core_rdata[2]), 32'h0);
        chk("abort_strobes", 32'(strobes(2)), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_ack", {30'd0, acks(2)} | 32'(busy[2]), 32'd0);
        end
        req_core(2, 1'b0, 9'h006, 16'h0);
        tick();
        core_req[2] = 1'b0;
        tick(4);
        chk("post_abort_ack", 32'(core_ack[2]), 32'd1);
        chk("post_abort_rdata", 32'(core_rdata[2]), 32'hA006);
        tick(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
